// File: rtl/kb_pkg.sv
// ---------------------------------------------------------------------------
// kb_pkg: shared types and constants for the PS/2 scan-code decoder.
//   - FSM state encoding for prefix parsing
//   - Set 2 scan-code constants and ASCII control characters
//   - translated-character payload struct and ignored-code helper
// ---------------------------------------------------------------------------
package kb_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kb_state_e;

   localparam logic [BYTE_W-1:0] SC_BRK    = 8'hF0;
   localparam logic [BYTE_W-1:0] SC_EXT    = 8'hE0;
   localparam logic [BYTE_W-1:0] SC_LSHIFT = 8'h12;
   localparam logic [BYTE_W-1:0] SC_RSHIFT = 8'h59;
   localparam logic [BYTE_W-1:0] SC_CAPS   = 8'h58;

   localparam logic [BYTE_W-1:0] ASCII_CR  = 8'h0D;
   localparam logic [BYTE_W-1:0] ASCII_BS  = 8'h08;
   localparam logic [BYTE_W-1:0] ASCII_TAB = 8'h09;
   localparam logic [BYTE_W-1:0] ASCII_SP  = 8'h20;

   typedef struct packed {
      logic              hit;
      logic [BYTE_W-1:0] ascii;
   } kb_char_t;

   // Keyboard status/response bytes that carry no key information
   function automatic logic is_ignored(input logic [BYTE_W-1:0] code);
      return (code == 8'h00) || (code == 8'hAA) || (code == 8'hEE) ||
             (code == 8'hFA) || (code == 8'hFE) || (code == 8'hFF);
   endfunction

endpackage

// File: rtl/kb_ascii_rom.sv
// ---------------------------------------------------------------------------
// kb_ascii_rom: combinational Set 2 (US layout) make code -> ASCII lookup.
//   i_shift    : a Shift key is held
//   i_caps     : CapsLock toggle state (affects letters only)
//   i_code     : make code
//   o_char_c   : {hit, ascii}; hit=0 for codes with no printable mapping
// ---------------------------------------------------------------------------
module kb_ascii_rom
   import kb_pkg::*;
(
   input  logic              i_shift,
   input  logic              i_caps,
   input  logic [BYTE_W-1:0] i_code,
   output kb_char_t          o_char_c
);

   logic              w_hit;
   logic              w_letter;
   logic [BYTE_W-1:0] w_lo;
   logic [BYTE_W-1:0] w_hi;

   // Table entry: unshifted / shifted glyph, plus letter flag
   always_comb begin
      w_hit    = 1'b1;
      w_letter = 1'b0;
      w_lo     = '0;
      w_hi     = '0;
      case (i_code)
         8'h1C: begin w_letter = 1'b1; {w_lo, w_hi} = {"a", "A"}; end
         8'h32: begin w_letter = 1'b1; {w_lo, w_hi} = {"b", "B"}; end
         8'h21: begin w_letter = 1'b1; {w_lo, w_hi} = {"c", "C"}; end
         8'h23: begin w_letter = 1'b1; {w_lo, w_hi} = {"d", "D"}; end
         8'h24: begin w_letter = 1'b1; {w_lo, w_hi} = {"e", "E"}; end
         8'h2B: begin w_letter = 1'b1; {w_lo, w_hi} = {"f", "F"}; end
         8'h34: begin w_letter = 1'b1; {w_lo, w_hi} = {"g", "G"}; end
         8'h33: begin w_letter = 1'b1; {w_lo, w_hi} = {"h", "H"}; end
         8'h43: begin w_letter = 1'b1; {w_lo, w_hi} = {"i", "I"}; end
         8'h3B: begin w_letter = 1'b1; {w_lo, w_hi} = {"j", "J"}; end
         8'h42: begin w_letter = 1'b1; {w_lo, w_hi} = {"k", "K"}; end
         8'h4B: begin w_letter = 1'b1; {w_lo, w_hi} = {"l", "L"}; end
         8'h3A: begin w_letter = 1'b1; {w_lo, w_hi} = {"m", "M"}; end
         8'h31: begin w_letter = 1'b1; {w_lo, w_hi} = {"n", "N"}; end
         8'h44: begin w_letter = 1'b1; {w_lo, w_hi} = {"o", "O"}; end
         8'h4D: begin w_letter = 1'b1; {w_lo, w_hi} = {"p", "P"}; end
         8'h15: begin w_letter = 1'b1; {w_lo, w_hi} = {"q", "Q"}; end
         8'h2D: begin w_letter = 1'b1; {w_lo, w_hi} = {"r", "R"}; end
         8'h1B: begin w_letter = 1'b1; {w_lo, w_hi} = {"s", "S"}; end
         8'h2C: begin w_letter = 1'b1; {w_lo, w_hi} = {"t", "T"}; end
         8'h3C: begin w_letter = 1'b1; {w_lo, w_hi} = {"u", "U"}; end
         8'h2A: begin w_letter = 1'b1; {w_lo, w_hi} = {"v", "V"}; end
         8'h1D: begin w_letter = 1'b1; {w_lo, w_hi} = {"w", "W"}; end
         8'h22: begin w_letter = 1'b1; {w_lo, w_hi} = {"x", "X"}; end
         8'h35: begin w_letter = 1'b1; {w_lo, w_hi} = {"y", "Y"}; end
         8'h1A: begin w_letter = 1'b1; {w_lo, w_hi} = {"z", "Z"}; end
         8'h16: {w_lo, w_hi} = {"1", "!"};
         8'h1E: {w_lo, w_hi} = {"2", "@"};
         8'h26: {w_lo, w_hi} = {"3", "#"};
         8'h25: {w_lo, w_hi} = {"4", "$"};
         8'h2E: {w_lo, w_hi} = {"5", "%"};
         8'h36: {w_lo, w_hi} = {"6", "^"};
         8'h3D: {w_lo, w_hi} = {"7", "&"};
         8'h3E: {w_lo, w_hi} = {"8", "*"};
         8'h46: {w_lo, w_hi} = {"9", "("};
         8'h45: {w_lo, w_hi} = {"0", ")"};
         8'h0E: {w_lo, w_hi} = {8'h60, "~"};
         8'h4E: {w_lo, w_hi} = {"-", "_"};
         8'h55: {w_lo, w_hi} = {"=", "+"};
         8'h54: {w_lo, w_hi} = {"[", "{"};
         8'h5B: {w_lo, w_hi} = {"]", "}"};
         8'h5D: {w_lo, w_hi} = {"\\", "|"};
         8'h4C: {w_lo, w_hi} = {";", ":"};
         8'h52: {w_lo, w_hi} = {"'", "\""};
         8'h41: {w_lo, w_hi} = {",", "<"};
         8'h49: {w_lo, w_hi} = {".", ">"};
         8'h4A: {w_lo, w_hi} = {"/", "?"};
         8'h29: {w_lo, w_hi} = {ASCII_SP,  ASCII_SP};
         8'h5A: {w_lo, w_hi} = {ASCII_CR,  ASCII_CR};
         8'h66: {w_lo, w_hi} = {ASCII_BS,  ASCII_BS};
         8'h0D: {w_lo, w_hi} = {ASCII_TAB, ASCII_TAB};
         default: w_hit = 1'b0;
      endcase
   end

   // Letters follow shift XOR caps; everything else follows shift alone
   always_comb begin
      o_char_c.hit   = w_hit;
      o_char_c.ascii = (w_letter ? (i_shift ^ i_caps) : i_shift) ? w_hi : w_lo;
   end

endmodule

// File: rtl/kb_scancode_decoder.sv
// ---------------------------------------------------------------------------
// kb_scancode_decoder: PS/2 byte stream -> ASCII character FIFO.
//   i_clk, i_rst_n    : clock, async active-low reset
//   i_scan_code       : received byte, stable while i_scan_flag high
//   i_scan_flag       : byte-ready flag, asynchronous to i_clk
//   o_ascii_data      : FIFO head character (FWFT)
//   o_ascii_valid     : FIFO not empty
//   i_ascii_ready     : consumer pops head when valid && ready
//   o_shift_active    : either Shift key held
//   o_caps_lock       : CapsLock toggle state
//   o_fifo_full       : FIFO holds FIFO_DEPTH entries
//   o_overflow        : sticky, a character was dropped on a full FIFO
// ---------------------------------------------------------------------------
module kb_scancode_decoder
   import kb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [BYTE_W-1:0] i_scan_code,
   input  logic              i_scan_flag,
   output logic [BYTE_W-1:0] o_ascii_data,
   output logic              o_ascii_valid,
   input  logic              i_ascii_ready,
   output logic              o_shift_active,
   output logic              o_caps_lock,
   output logic              o_fifo_full,
   output logic              o_overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   // ---------------- input capture ----------------
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_flag_d;
   logic                   r_byte_stb;
   logic [BYTE_W-1:0]      r_byte_q;
   logic                   w_flag_rise;

   assign w_flag_rise = r_sync[SYNC_STAGES-1] & ~r_flag_d;

   // Synchronize the flag, then register the byte on its rising edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync     <= '0;
         r_flag_d   <= 1'b0;
         r_byte_stb <= 1'b0;
         r_byte_q   <= '0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], i_scan_flag};
         r_flag_d   <= r_sync[SYNC_STAGES-1];
         r_byte_stb <= w_flag_rise;
         if (w_flag_rise) r_byte_q <= i_scan_code;
      end
   end

   // ---------------- prefix FSM ----------------
   kb_state_e r_state, w_state_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_byte_stb) begin
         case (r_state)
            ST_IDLE: begin
               if (r_byte_q == SC_BRK)      w_state_nxt = ST_BRK;
               else if (r_byte_q == SC_EXT) w_state_nxt = ST_EXT;
            end
            ST_BRK:     w_state_nxt = ST_IDLE;
            ST_EXT:     w_state_nxt = (r_byte_q == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
            ST_EXT_BRK: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // ---------------- key state and translation ----------------
   logic              r_lshift, r_rshift, r_caps, r_caps_held, r_shift_active;
   logic              w_lshift_nxt, w_rshift_nxt, w_caps_nxt, w_caps_held_nxt;
   logic              w_make, w_break, w_push_c;
   logic              r_push;
   logic [BYTE_W-1:0] r_push_data;
   kb_char_t          w_rom_char;

   kb_ascii_rom u_rom (
      .i_shift  (r_lshift | r_rshift),
      .i_caps   (r_caps),
      .i_code   (r_byte_q),
      .o_char_c (w_rom_char)
   );

   // Make/break actions on modifier state and character push request
   always_comb begin
      w_lshift_nxt    = r_lshift;
      w_rshift_nxt    = r_rshift;
      w_caps_nxt      = r_caps;
      w_caps_held_nxt = r_caps_held;
      w_push_c        = 1'b0;
      w_make  = r_byte_stb && (r_state == ST_IDLE) && (r_byte_q != SC_BRK) &&
                (r_byte_q != SC_EXT) && !is_ignored(r_byte_q);
      w_break = r_byte_stb && (r_state == ST_BRK);
      if (w_make) begin
         if (r_byte_q == SC_LSHIFT)      w_lshift_nxt = 1'b1;
         else if (r_byte_q == SC_RSHIFT) w_rshift_nxt = 1'b1;
         else if (r_byte_q == SC_CAPS) begin
            // Typematic repeats of CapsLock must not re-toggle
            if (!r_caps_held) begin
               w_caps_nxt      = ~r_caps;
               w_caps_held_nxt = 1'b1;
            end
         end else begin
            w_push_c = w_rom_char.hit;
         end
      end
      if (w_break) begin
         if (r_byte_q == SC_LSHIFT) w_lshift_nxt    = 1'b0;
         if (r_byte_q == SC_RSHIFT) w_rshift_nxt    = 1'b0;
         if (r_byte_q == SC_CAPS)   w_caps_held_nxt = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lshift       <= 1'b0;
         r_rshift       <= 1'b0;
         r_caps         <= 1'b0;
         r_caps_held    <= 1'b0;
         r_shift_active <= 1'b0;
         r_push         <= 1'b0;
         r_push_data    <= '0;
      end else begin
         r_lshift       <= w_lshift_nxt;
         r_rshift       <= w_rshift_nxt;
         r_caps         <= w_caps_nxt;
         r_caps_held    <= w_caps_held_nxt;
         r_shift_active <= w_lshift_nxt | w_rshift_nxt;
         r_push         <= w_push_c;
         r_push_data    <= w_rom_char.ascii;
      end
   end

   // ---------------- character FIFO ----------------
   logic [BYTE_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [PW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic              r_valid, r_full, r_ovf;
   logic [BYTE_W-1:0] r_head;
   logic              w_full, w_pop, w_wr_en, w_drop;
   logic              w_empty_nxt, w_full_nxt;
   logic [BYTE_W-1:0] w_head_nxt;

   always_comb begin
      w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      w_pop   = r_valid && i_ascii_ready;
      // A pop in the same cycle frees the slot a full FIFO needs
      w_wr_en = r_push && (!w_full || w_pop);
      w_drop  = r_push && w_full && !w_pop;
      w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_en);
      w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
      w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
      w_full_nxt   = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                     (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
      // Bypass the write when it lands on the slot becoming head
      if (w_wr_en && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0]))
         w_head_nxt = r_push_data;
      else
         w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_valid  <= 1'b0;
         r_full   <= 1'b0;
         r_ovf    <= 1'b0;
         r_head   <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_valid  <= ~w_empty_nxt;
         r_full   <= w_full_nxt;
         r_ovf    <= r_ovf | w_drop;
         r_head   <= w_head_nxt;
      end
   end

   assign o_ascii_data   = r_head;
   assign o_ascii_valid  = r_valid;
   assign o_shift_active = r_shift_active;
   assign o_caps_lock    = r_caps;
   assign o_fifo_full    = r_full;
   assign o_overflow     = r_ovf;

endmodule

// File: tb/tb_kb_scancode_decoder.sv
// ---------------------------------------------------------------------------
// tb_kb_scancode_decoder: directed scan-code sequences against a keyboard
// model (modifier flags + expected character queue), with literal spot checks.
// ---------------------------------------------------------------------------
module tb_kb_scancode_decoder;

   localparam int unsigned DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] scan_code;
   logic       scan_flag;
   logic [7:0] ascii_data;
   logic       ascii_valid;
   logic       ascii_ready;
   logic       shift_active, caps_lock, fifo_full, overflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   kb_scancode_decoder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_scan_code    (scan_code),
      .i_scan_flag    (scan_flag),
      .o_ascii_data   (ascii_data),
      .o_ascii_valid  (ascii_valid),
      .i_ascii_ready  (ascii_ready),
      .o_shift_active (shift_active),
      .o_caps_lock    (caps_lock),
      .o_fifo_full    (fifo_full),
      .o_overflow     (overflow)
   );

   // ---------------- keyboard model ----------------
   logic [7:0] t_lo  [256];
   logic [7:0] t_hi  [256];
   logic       t_hit [256];
   logic       t_let [256];
   logic [7:0] exp_q [$];
   logic m_brk, m_ext, m_extbrk, m_ls, m_rs, m_caps, m_held, m_ovf;
   logic settled;

   task automatic add(input logic [7:0] c, input logic [7:0] lo, input logic [7:0] hi,
                      input logic letter);
      t_lo[c] = lo; t_hi[c] = hi; t_hit[c] = 1'b1; t_let[c] = letter;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_brk = 0; m_ext = 0; m_extbrk = 0;
      m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0; m_ovf = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic sh;
      logic [7:0] ch;
      sh = m_ls | m_rs;
      if (m_brk) begin
         m_brk = 0;
         if (b == 8'h12) m_ls = 0;
         if (b == 8'h59) m_rs = 0;
         if (b == 8'h58) m_held = 0;
      end else if (m_ext) begin
         m_ext = 0;
         if (b == 8'hF0) m_extbrk = 1;
      end else if (m_extbrk) begin
         m_extbrk = 0;
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
               b == 8'hFE || b == 8'hFF) begin
      end else if (b == 8'h12) m_ls = 1;
      else if (b == 8'h59) m_rs = 1;
      else if (b == 8'h58) begin
         if (!m_held) begin m_caps = ~m_caps; m_held = 1; end
      end else if (t_hit[b]) begin
         if (t_let[b]) ch = (sh ^ m_caps) ? t_hi[b] : t_lo[b];
         else          ch = sh ? t_hi[b] : t_lo[b];
         if (exp_q.size() >= DEPTH) m_ovf = 1;
         else exp_q.push_back(ch);
      end
   endtask

   function automatic void check(input string nm, input logic [7:0] act,
                                 input logic [7:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
      end
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (settled && rst_n) begin
         check("valid", 8'(ascii_valid), 8'(exp_q.size() != 0));
         check("full",  8'(fifo_full),   8'(exp_q.size() == DEPTH));
         check("shift", 8'(shift_active), 8'(m_ls | m_rs));
         check("caps",  8'(caps_lock),   8'(m_caps));
         check("ovf",   8'(overflow),    8'(m_ovf));
      end
      if (rst_n && ascii_valid && ascii_ready) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL pop: got %h want none at %0t", ascii_data, $time);
         end else begin
            check("data", ascii_data, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] b);
      settled = 0;
      @(posedge clk); #1;
      scan_code = b; scan_flag = 1'b1;
      model_byte(b);
      repeat (6) @(posedge clk);
      #1 scan_flag = 1'b0;
      repeat (8) @(posedge clk);
      #1 settled = 1;
   endtask

   task automatic expect_head(input string nm, input logic [7:0] lit);
      check({nm, "_valid"}, 8'(ascii_valid), 8'h01);
      check({nm, "_data"}, ascii_data, lit);
      ascii_ready = 1'b1;
      @(posedge clk); #1 ascii_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                     8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                     8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                     8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      for (int i = 0; i < 256; i++) begin
         t_lo[i] = 0; t_hi[i] = 0; t_hit[i] = 0; t_let[i] = 0;
      end
      for (int i = 0; i < 26; i++) add(let_codes[i], 8'(8'h61 + i), 8'(8'h41 + i), 1'b1);
      add(8'h16, "1", "!", 0); add(8'h1E, "2", "@", 0); add(8'h26, "3", "#", 0);
      add(8'h25, "4", "$", 0); add(8'h2E, "5", "%", 0); add(8'h36, "6", "^", 0);
      add(8'h3D, "7", "&", 0); add(8'h3E, "8", "*", 0); add(8'h46, "9", "(", 0);
      add(8'h45, "0", ")", 0); add(8'h0E, 8'h60, "~", 0); add(8'h4E, "-", "_", 0);
      add(8'h55, "=", "+", 0); add(8'h54, "[", "{", 0); add(8'h5B, "]", "}", 0);
      add(8'h5D, "\\", "|", 0); add(8'h4C, ";", ":", 0); add(8'h52, "'", "\"", 0);
      add(8'h41, ",", "<", 0); add(8'h49, ".", ">", 0); add(8'h4A, "/", "?", 0);
      add(8'h29, 8'h20, 8'h20, 0); add(8'h5A, 8'h0D, 8'h0D, 0);
      add(8'h66, 8'h08, 8'h08, 0); add(8'h0D, 8'h09, 8'h09, 0);

      model_reset();
      settled = 0; rst_n = 1'b0; scan_code = 0; scan_flag = 0; ascii_ready = 0;
      repeat (3) @(posedge clk); #1;
      check("rst_valid", 8'(ascii_valid), 8'h00);
      check("rst_data",  ascii_data, 8'h00);
      check("rst_shift", 8'(shift_active), 8'h00);
      check("rst_caps",  8'(caps_lock), 8'h00);
      check("rst_full",  8'(fifo_full), 8'h00);
      check("rst_ovf",   8'(overflow), 8'h00);
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1 settled = 1;

      // 1: make then break of 'a'
      send(8'h1C); send(8'hF0); send(8'h1C);
      expect_head("t1", 8'h61);
      #1 check("t1_empty", 8'(ascii_valid), 8'h00);

      // 2: shifted letter
      send(8'h12);
      check("t2_shift_on", 8'(shift_active), 8'h01);
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      check("t2_shift_off", 8'(shift_active), 8'h00);
      expect_head("t2", 8'h41);

      // 3: CapsLock, caps+shift cancel, digits use shift only
      send(8'h58); send(8'hF0); send(8'h58);
      check("t3_caps", 8'(caps_lock), 8'h01);
      send(8'h1C); send(8'h12); send(8'h1C); send(8'h16);
      expect_head("t3a", 8'h41);
      expect_head("t3b", 8'h61);
      expect_head("t3c", 8'h21);
      send(8'hF0); send(8'h12);
      send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
      check("t3_typematic", 8'(caps_lock), 8'h00);

      // 4: extended make/break ignored, status bytes ignored
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hFA); send(8'h16); send(8'h5A); send(8'h1C);
      expect_head("t4a", 8'h31);
      expect_head("t4b", 8'h0D);
      expect_head("t4c", 8'h61);

      // 5: fill, push+pop while full, overflow, drain
      for (int i = 0; i < DEPTH; i++) send(8'h1C);
      check("t5_full", 8'(fifo_full), 8'h01);
      check("t5_ovf0", 8'(overflow), 8'h00);
      settled = 0;
      @(posedge clk); #1 scan_code = 8'h32; scan_flag = 1'b1;
      // write lands on the 4th edge after the first one sampling the flag
      repeat (4) @(posedge clk);
      #1 ascii_ready = 1'b1;
      #5 model_byte(8'h32);
      @(posedge clk); #1 ascii_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 scan_flag = 1'b0;
      repeat (8) @(posedge clk);
      #1 settled = 1;
      check("t5_full_pp", 8'(fifo_full), 8'h01);
      check("t5_ovf_pp",  8'(overflow), 8'h00);
      send(8'h1C);
      check("t5_ovf1", 8'(overflow), 8'h01);
      check("t5_head", ascii_data, 8'h61);
      ascii_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1 ascii_ready = 1'b0;
      check("t5_drained", 8'(ascii_valid), 8'h00);

      // 6: reset discards pending break prefix and modifier state
      send(8'h58); send(8'hF0); send(8'h58); send(8'h12); send(8'hF0);
      check("t6_caps_pre", 8'(caps_lock), 8'h01);
      settled = 0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk); #1;
      check("t6_caps",  8'(caps_lock), 8'h00);
      check("t6_shift", 8'(shift_active), 8'h00);
      check("t6_valid", 8'(ascii_valid), 8'h00);
      check("t6_ovf",   8'(overflow), 8'h00);
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1 settled = 1;
      send(8'h1C);
      expect_head("t6", 8'h61);

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
